inst_fetch: RTL and testbench

Instruction-fetch stage of the out-of-order RISC-V core. Holds the PC, serves instructions from a direct-mapped instruction cache, and fetches misses through the memory controller. Predicts JAL and conditional branches with a 2-bit BHT and delivers one instruction per cycle to the decoder through a valid/stall handshake. Redirects to the correct PC when the ROB reports a misprediction.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch_branch_predictor.sv | 27 ++
 rtl/inst_fetch.sv | 92 +++++++++
 tb/tb_inst_fetch.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, fetch FSM states and immediate decoders
package inst_fetch_pkg;
  localparam int ICACHE_LINES = 256;
  localparam int BHT_SIZE = 256;
  localparam int IDX_W = 8;
  localparam logic [6:0] OP_JAL = 7'd111;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [31:0] NULL32 = 32'd0;
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} state_e;
  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: decoder handshake, ROB redirect/BHT update and memory-controller read port
interface inst_fetch_if;
  logic stall_IF;
  logic ins_flag;
  logic [31:0] ins;
  logic jp_flag;
  logic [31:0] jp_pc;
  logic jp_wrong;
  logic [31:0] jp_target;
  logic bht_upd;
  logic [31:0] bht_pc;
  logic bht_taken;
  logic mc_req;
  logic [31:0] mc_addr;
  logic mc_done;
  logic [31:0] mc_data;
  modport master (
    input stall_IF, jp_wrong, jp_target, bht_upd, bht_pc, bht_taken, mc_done, mc_data,
    output ins_flag, ins, jp_flag, jp_pc, mc_req, mc_addr
  );
  modport slave (
    output stall_IF, jp_wrong, jp_target, bht_upd, bht_pc, bht_taken, mc_done, mc_data,
    input ins_flag, ins, jp_flag, jp_pc, mc_req, mc_addr
  );
endinterface

// File: rtl/inst_fetch_branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters with one read and one update port
module branch_predictor
  import inst_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  logic [1:0] cnt_q [BHT_SIZE];
  logic [1:0] cnt_d;
  // saturating step of the counter being resolved
  always_comb begin
    cnt_d = upd_taken ? ((cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'd1)
                      : ((cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'd1);
  end
  // counters start weakly not-taken; updates only while the core is running
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < BHT_SIZE; i++) cnt_q[i] <= 2'b01;
    else if (en && upd) cnt_q[upd_idx] <= cnt_d;
  end
  assign rd_taken = cnt_q[rd_idx][1];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, direct-mapped I-cache, miss fetch, BHT/JAL prediction and decoder handshake
module inst_fetch
  import inst_fetch_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic rdy,
  inst_fetch_if.master bus
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ins_q, ins_d, jp_pc_q, jp_pc_d, mc_addr_q, mc_addr_d;
  logic ins_flag_q, ins_flag_d, jp_flag_q, jp_flag_d, mc_req_q, mc_req_d;
  logic valid_q [ICACHE_LINES];
  logic [21:0] tag_q [ICACHE_LINES];
  logic [31:0] data_q [ICACHE_LINES];
  logic [IDX_W-1:0] idx, fill_idx;
  logic [31:0] line, pred_pc;
  logic hit, bp_taken, pred_taken, fill, present, miss;
  logic unused_bits;
  assign unused_bits = ^{bus.bht_pc[31:10], bus.bht_pc[1:0]};
  assign idx = pc_q[9:2];
  assign fill_idx = mc_addr_q[9:2];
  assign line = data_q[idx];
  assign hit = valid_q[idx] && tag_q[idx] == pc_q[31:10];
  assign pred_taken = line[6:0] == OP_JAL || (line[6:0] == OP_BRANCH && bp_taken);
  assign pred_pc = line[6:0] == OP_JAL ? pc_q + j_imm(line) : pred_taken ? pc_q + b_imm(line) : pc_q + 32'd4;
  // a read in flight always lands in the cache, even after a flush
  assign fill = state_q != S_FETCH && bus.mc_done;
  assign present = state_q == S_FETCH && hit && (!ins_flag_q || !bus.stall_IF) && !bus.jp_wrong;
  assign miss = state_q == S_FETCH && !hit && !bus.jp_wrong;
  branch_predictor u_bp (
    .clk(clk), .rst(rst), .en(rdy), .rd_idx(idx), .rd_taken(bp_taken),
    .upd(bus.bht_upd), .upd_idx(bus.bht_pc[9:2]), .upd_taken(bus.bht_taken)
  );
  // next-state: present on hit, request on miss, redirect overrides both
  always_comb begin
    state_d = fill ? S_FETCH : state_q;
    pc_d = present ? pred_pc : pc_q;
    ins_d = present ? line : ins_q;
    jp_pc_d = present ? pc_q : jp_pc_q;
    jp_flag_d = present ? pred_taken : jp_flag_q;
    ins_flag_d = present || (ins_flag_q && bus.stall_IF);
    mc_req_d = miss || (mc_req_q && !fill);
    mc_addr_d = miss ? {pc_q[31:2], 2'b00} : mc_addr_q;
    if (miss) state_d = S_WAIT;
    if (bus.jp_wrong) begin
      ins_flag_d = FALSE;
      pc_d = bus.jp_target;
      state_d = (state_q != S_FETCH && !bus.mc_done) ? S_DISCARD : S_FETCH;
    end
  end
  // FSM and registered outputs; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= NULL32;
      ins_q <= NULL32;
      jp_pc_q <= NULL32;
      jp_flag_q <= FALSE;
      ins_flag_q <= FALSE;
      mc_req_q <= FALSE;
      mc_addr_q <= NULL32;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q <= pc_d;
      ins_q <= ins_d;
      jp_pc_q <= jp_pc_d;
      jp_flag_q <= jp_flag_d;
      ins_flag_q <= ins_flag_d;
      mc_req_q <= mc_req_d;
      mc_addr_q <= mc_addr_d;
    end
  end
  // valid bits are cleared by reset and set by each completed fill
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < ICACHE_LINES; i++) valid_q[i] <= FALSE;
    else if (rdy && fill) valid_q[fill_idx] <= TRUE;
  end
  // tag and data storage need no reset
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_q[fill_idx] <= mc_addr_q[31:10];
      data_q[fill_idx] <= bus.mc_data;
    end
  end
  assign bus.ins_flag = ins_flag_q;
  assign bus.ins = ins_q;
  assign bus.jp_flag = jp_flag_q;
  assign bus.jp_pc = jp_pc_q;
  assign bus.mc_req = mc_req_q;
  assign bus.mc_addr = mc_addr_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a scoreboard of expected delivered instructions
module tb_inst_fetch;
  import inst_fetch_pkg::*;
  typedef struct {logic [31:0] ins; logic [31:0] pc; logic flag;} exp_t;
  localparam int LAT = 3;
  localparam logic [31:0] ADDI0 = 32'h00100093, NOP = 32'h00000013;
  localparam logic [31:0] JAL10 = 32'h0200006F, BEQ30 = 32'h00000863, ADDI100 = 32'h00500293;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, mem_on = 1'b0;
  logic [31:0] mem [1024];
  exp_t sb [$];
  int pop_cyc [$];
  int cyc = 0, pass_cnt = 0, total_cnt = 0, cnt = 0;
  inst_fetch_if ifc ();
  inst_fetch dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(ifc.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_ins(input logic [31:0] i, input logic [31:0] p, input logic f);
    sb.push_back(exp_t'{ins: i, pc: p, flag: f});
  endtask
  task automatic wait_req(input logic [31:0] a, input string nm);
    mem_on = 1'b1;
    for (int n = 0; n < 400 && !(ifc.mc_req && ifc.mc_addr == a); n++) tick();
    mem_on = 1'b0;
    chk(nm, ifc.mc_req ? ifc.mc_addr : 32'hdeadbeef, a);
  endtask

  // memory controller model: answers a held request after LAT cycles
  initial begin
    ifc.mc_done = 1'b0;
    ifc.mc_data = '0;
    forever begin
      @(negedge clk);
      if (ifc.mc_done) begin
        ifc.mc_done = 1'b0;
        cnt = 0;
      end else if (mem_on && ifc.mc_req) begin
        if (cnt == LAT - 1) begin
          ifc.mc_done = 1'b1;
          ifc.mc_data = mem[ifc.mc_addr[11:2]];
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // monitor: every consumed slot must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ifc.ins_flag && !ifc.stall_IF) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_ins: got pc %h ins %h, expected none", ifc.jp_pc, ifc.ins);
        end else begin
          e = sb.pop_front();
          chk("ins", ifc.ins, e.ins);
          chk("jp_pc", ifc.jp_pc, e.pc);
          chk("jp_flag", {31'b0, ifc.jp_flag}, {31'b0, e.flag});
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
    mem[0] = ADDI0; mem[1] = 32'h00200113; mem[2] = 32'h00300193; mem[3] = 32'h00400213;
    mem[4] = JAL10; mem[12] = BEQ30; mem[64] = ADDI100;
    ifc.stall_IF = 1'b0; ifc.jp_wrong = 1'b0; ifc.jp_target = '0;
    ifc.bht_upd = 1'b0; ifc.bht_pc = '0; ifc.bht_taken = 1'b0;
    tick(); tick();
    chk("rst_ins_flag", {31'b0, ifc.ins_flag}, 0);
    chk("rst_ins", ifc.ins, 0);
    chk("rst_jp_pc", ifc.jp_pc, 0);
    chk("rst_jp_flag", {31'b0, ifc.jp_flag}, 0);
    chk("rst_mc_req", {31'b0, ifc.mc_req}, 0);
    chk("rst_mc_addr", ifc.mc_addr, 0);
    rst = 1'b0;
    // cold start, straight line, JAL and not-taken BEQ, all missing
    wait_req(32'h0, "cold_req0");
    expect_ins(ADDI0, 32'h0, 0); expect_ins(32'h00200113, 32'h4, 0);
    expect_ins(32'h00300193, 32'h8, 0); expect_ins(32'h00400213, 32'hC, 0);
    expect_ins(JAL10, 32'h10, 1); expect_ins(BEQ30, 32'h30, 0); expect_ins(NOP, 32'h34, 0);
    wait_req(32'h38, "req_38");
    chk("drain_cold", sb.size(), 0);
    // flush during WAIT: stale word must not be delivered
    ifc.jp_wrong = 1'b1; ifc.jp_target = 32'h100;
    tick();
    ifc.jp_wrong = 1'b0;
    chk("discard_state", 32'(dut.state_q), 32'(S_DISCARD));
    chk("discard_flag", {31'b0, ifc.ins_flag}, 0);
    chk("discard_req_held", ifc.mc_req ? ifc.mc_addr : 32'hdeadbeef, 32'h38);
    expect_ins(ADDI100, 32'h100, 0);
    wait_req(32'h104, "req_104");
    chk("drain_discard", sb.size(), 0);
    // redirect to 0: everything up to 0x38 is cached and streams back to back
    ifc.jp_wrong = 1'b1; ifc.jp_target = 32'h0;
    tick();
    ifc.jp_wrong = 1'b0;
    pop_cyc.delete();
    expect_ins(ADDI0, 32'h0, 0); expect_ins(32'h00200113, 32'h4, 0);
    expect_ins(32'h00300193, 32'h8, 0); expect_ins(32'h00400213, 32'hC, 0);
    expect_ins(JAL10, 32'h10, 1); expect_ins(BEQ30, 32'h30, 0);
    expect_ins(NOP, 32'h34, 0); expect_ins(NOP, 32'h38, 0);
    wait_req(32'h3C, "req_3c");
    chk("drain_hits", sb.size(), 0);
    chk("burst_span", pop_cyc.size() == 8 ? 32'(pop_cyc[7] - pop_cyc[0]) : 32'hffffffff, 7);
    // stall holds the slot; next word follows one edge after release
    ifc.stall_IF = 1'b1;
    ifc.jp_wrong = 1'b1; ifc.jp_target = 32'h0;
    mem_on = 1'b1;
    tick();
    ifc.jp_wrong = 1'b0;
    expect_ins(ADDI0, 32'h0, 0); expect_ins(32'h00200113, 32'h4, 0);
    expect_ins(32'h00300193, 32'h8, 0); expect_ins(32'h00400213, 32'hC, 0);
    expect_ins(JAL10, 32'h10, 1); expect_ins(BEQ30, 32'h30, 0);
    expect_ins(NOP, 32'h34, 0); expect_ins(NOP, 32'h38, 0); expect_ins(NOP, 32'h3C, 0);
    for (int n = 0; n < 100 && !ifc.ins_flag; n++) tick();
    repeat (3) tick();
    chk("stall_flag", {31'b0, ifc.ins_flag}, 1);
    chk("stall_ins", ifc.ins, ADDI0);
    chk("stall_jp_pc", ifc.jp_pc, 32'h0);
    ifc.stall_IF = 1'b0;
    tick();
    chk("unstall_jp_pc", ifc.jp_pc, 32'h4);
    chk("unstall_flag", {31'b0, ifc.ins_flag}, 1);
    wait_req(32'h40, "req_40");
    chk("drain_stall", sb.size(), 0);
    // train BEQ to taken; second update coincides with the redirect
    ifc.bht_upd = 1'b1; ifc.bht_taken = 1'b1; ifc.bht_pc = 32'h30;
    tick();
    ifc.jp_wrong = 1'b1; ifc.jp_target = 32'h30;
    tick();
    ifc.jp_wrong = 1'b0; ifc.bht_upd = 1'b0;
    expect_ins(BEQ30, 32'h30, 1); expect_ins(NOP, 32'h40, 0);
    wait_req(32'h44, "req_44");
    chk("drain_bht", sb.size(), 0);
    // reset mid-WAIT clears outputs and cache
    rst = 1'b1;
    tick();
    chk("rst2_ins_flag", {31'b0, ifc.ins_flag}, 0);
    chk("rst2_ins", ifc.ins, 0);
    chk("rst2_jp_pc", ifc.jp_pc, 0);
    chk("rst2_jp_flag", {31'b0, ifc.jp_flag}, 0);
    chk("rst2_mc_req", {31'b0, ifc.mc_req}, 0);
    chk("rst2_mc_addr", ifc.mc_addr, 0);
    rst = 1'b0;
    wait_req(32'h0, "rst2_req0");
    expect_ins(ADDI0, 32'h0, 0);
    wait_req(32'h4, "rst2_req4");
    chk("drain_rst", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
